// File: rtl/wb_stage_if.sv
// Bundle of the writeback stage's datapath signals: memory-stage result in,
// decode read ports, EX forwarding tap and retired-instruction counter out.
interface wb_stage_if #(
    parameter int unsigned XLEN = 32
);
    // Memory stage -> writeback
    logic [3:0]      rd_in;
    logic [XLEN-1:0] alu_in;
    logic [XLEN-1:0] mem_data_in;
    logic            is_load_in;
    logic [2:0]      ld_type_in;
    logic            valid_in;

    // Decode read ports
    logic [3:0]      rs1_addr;
    logic [3:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    // EX forwarding tap
    logic            fwd_valid;
    logic [3:0]      fwd_rd;
    logic [XLEN-1:0] fwd_data;

    // Retired-instruction counter
    logic [31:0]     retire_count;

    // Environment side: drives the memory-stage result and read addresses
    modport master (
        output rd_in, alu_in, mem_data_in, is_load_in, ld_type_in, valid_in,
        output rs1_addr, rs2_addr,
        input  rs1_data, rs2_data,
        input  fwd_valid, fwd_rd, fwd_data,
        input  retire_count
    );

    // Writeback stage side
    modport slave (
        input  rd_in, alu_in, mem_data_in, is_load_in, ld_type_in, valid_in,
        input  rs1_addr, rs2_addr,
        output rs1_data, rs2_data,
        output fwd_valid, fwd_rd, fwd_data,
        output retire_count
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load extraction/extension,
// 16 x XLEN register file with write-through bypass on the read ports,
// forwarding tap and retired-instruction counter.
module wb_stage #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned XLEN     = 32
) (
    input logic         clk,
    input logic         rst,
    wb_stage_if.slave   bus
);

    logic            r_wb_valid_q;
    logic [3:0]      r_wb_rd_q;
    logic [XLEN-1:0] r_wb_data_q;
    logic [XLEN-1:0] r_regs [NUM_REGS];
    logic [31:0]     r_retire_count;

    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_result;
    logic            w_commit;
    logic            w_bypass1;
    logic            w_bypass2;

    // Load data: pick the addressed byte/half and sign- or zero-extend it
    always_comb begin
        w_byte      = '0;
        w_half      = '0;
        w_load_data = '0;
        case (bus.alu_in[1:0])
            2'd0:    w_byte = bus.mem_data_in[7:0];
            2'd1:    w_byte = bus.mem_data_in[15:8];
            2'd2:    w_byte = bus.mem_data_in[23:16];
            default: w_byte = bus.mem_data_in[31:24];
        endcase
        w_half = bus.alu_in[1] ? bus.mem_data_in[31:16] : bus.mem_data_in[15:0];
        case (bus.ld_type_in[1:0])
            2'b00: begin
                if (bus.ld_type_in[2])
                    w_load_data = {{(XLEN-8){1'b0}}, w_byte};
                else
                    w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            end
            2'b01: begin
                if (bus.ld_type_in[2])
                    w_load_data = {{(XLEN-16){1'b0}}, w_half};
                else
                    w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            end
            // Word and the reserved size both pass the full word through
            default: w_load_data = bus.mem_data_in;
        endcase
        w_result = bus.is_load_in ? w_load_data : bus.alu_in;
    end

    // MEM/WB pipeline register, loaded every cycle (no stall)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid_q <= 1'b0;
            r_wb_rd_q    <= '0;
            r_wb_data_q  <= '0;
        end else begin
            r_wb_valid_q <= bus.valid_in;
            r_wb_rd_q    <= bus.rd_in;
            r_wb_data_q  <= w_result;
        end
    end

    assign w_commit = r_wb_valid_q && (r_wb_rd_q != 4'd0);

    // Register file commit; r0 is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[r_wb_rd_q] <= r_wb_data_q;
        end
    end

    // Retired-instruction counter, counts rd = 0 retirements too, wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_count <= '0;
        end else if (r_wb_valid_q) begin
            r_retire_count <= r_retire_count + 32'd1;
        end
    end

    assign w_bypass1 = w_commit && (bus.rs1_addr == r_wb_rd_q);
    assign w_bypass2 = w_commit && (bus.rs2_addr == r_wb_rd_q);

    // Combinational read ports with write-through bypass; r0 reads as zero
    always_comb begin
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        if (bus.rs1_addr != 4'd0)
            bus.rs1_data = w_bypass1 ? r_wb_data_q : r_regs[bus.rs1_addr];
        if (bus.rs2_addr != 4'd0)
            bus.rs2_data = w_bypass2 ? r_wb_data_q : r_regs[bus.rs2_addr];
    end

    assign bus.fwd_valid    = w_commit;
    assign bus.fwd_rd       = r_wb_rd_q;
    assign bus.fwd_data     = r_wb_data_q;
    assign bus.retire_count = r_retire_count;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;

    logic clk;
    logic rst;
    int   checks_total;
    int   checks_passed;

    wb_stage_if #(.XLEN(32)) bus ();

    wb_stage #(.NUM_REGS(16), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] rd, input logic [31:0] alu,
                         input logic [31:0] mem, input logic ld, input logic [2:0] lt);
        bus.valid_in    = v;
        bus.rd_in       = rd;
        bus.alu_in      = alu;
        bus.mem_data_in = mem;
        bus.is_load_in  = ld;
        bus.ld_type_in  = lt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 4'd9, 32'h5555_AAAA, 32'h0, 1'b0, 3'b010);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 3'b000);
        checks_total++;
        if (bus.fwd_valid !== 1'b0) $display("FAIL reset_fwd_valid got=%b exp=0", bus.fwd_valid);
        else checks_passed++;
        checks_total++;
        if (bus.fwd_rd !== 4'd0) $display("FAIL reset_fwd_rd got=%0d exp=0", bus.fwd_rd);
        else checks_passed++;
        checks_total++;
        if (bus.fwd_data !== 32'h0) $display("FAIL reset_fwd_data got=%h exp=0", bus.fwd_data);
        else checks_passed++;
        checks_total++;
        if (bus.retire_count !== 32'h0) $display("FAIL reset_retire got=%h exp=0", bus.retire_count);
        else checks_passed++;
        for (int a = 0; a < 16; a++) begin
            bus.rs1_addr = 4'(a);
            bus.rs2_addr = 4'(15 - a);
            #1;
            checks_total++;
            if (bus.rs1_data !== 32'h0) $display("FAIL reset_rs1[%0d] got=%h exp=0", a, bus.rs1_data);
            else checks_passed++;
            checks_total++;
            if (bus.rs2_data !== 32'h0) $display("FAIL reset_rs2[%0d] got=%h exp=0", 15 - a, bus.rs2_data);
            else checks_passed++;
        end
    endtask

    task automatic test_alu_write();
        drive(1'b1, 4'd5, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 3'b000);
        tick();
        drive(1'b0, 4'd5, 32'hAAAA_AAAA, 32'h0, 1'b0, 3'b000);
        bus.rs1_addr = 4'd5;
        bus.rs2_addr = 4'd5;
        #1;
        checks_total++;
        if (bus.fwd_valid !== 1'b1) $display("FAIL alu_fwd_valid got=%b exp=1", bus.fwd_valid);
        else checks_passed++;
        checks_total++;
        if (bus.fwd_rd !== 4'd5) $display("FAIL alu_fwd_rd got=%0d exp=5", bus.fwd_rd);
        else checks_passed++;
        checks_total++;
        if (bus.fwd_data !== 32'h1234_5678) $display("FAIL alu_fwd_data got=%h exp=12345678", bus.fwd_data);
        else checks_passed++;
        checks_total++;
        if (bus.rs1_data !== 32'h1234_5678) $display("FAIL alu_bypass_rs1 got=%h exp=12345678", bus.rs1_data);
        else checks_passed++;
        checks_total++;
        if (bus.rs2_data !== 32'h1234_5678) $display("FAIL alu_bypass_rs2 got=%h exp=12345678", bus.rs2_data);
        else checks_passed++;
        checks_total++;
        if (bus.retire_count !== 32'd0) $display("FAIL alu_retire_early got=%0d exp=0", bus.retire_count);
        else checks_passed++;
        tick();
        checks_total++;
        if (bus.fwd_valid !== 1'b0) $display("FAIL alu_bubble_fwd got=%b exp=0", bus.fwd_valid);
        else checks_passed++;
        checks_total++;
        if (bus.rs1_data !== 32'h1234_5678) $display("FAIL alu_rf_rs1 got=%h exp=12345678", bus.rs1_data);
        else checks_passed++;
        checks_total++;
        if (bus.retire_count !== 32'd1) $display("FAIL alu_retire got=%0d exp=1", bus.retire_count);
        else checks_passed++;
    endtask

    task automatic test_loads();
        logic [2:0]  lt  [11];
        logic [1:0]  off [11];
        logic [31:0] exp [11];
        lt[0]  = 3'b000; off[0]  = 2'd3; exp[0]  = 32'hFFFF_FF80;
        lt[1]  = 3'b100; off[1]  = 2'd0; exp[1]  = 32'h0000_0001;
        lt[2]  = 3'b001; off[2]  = 2'd2; exp[2]  = 32'hFFFF_80FF;
        lt[3]  = 3'b101; off[3]  = 2'd0; exp[3]  = 32'h0000_7F01;
        lt[4]  = 3'b010; off[4]  = 2'd1; exp[4]  = 32'h80FF_7F01;
        lt[5]  = 3'b000; off[5]  = 2'd1; exp[5]  = 32'h0000_007F;
        lt[6]  = 3'b100; off[6]  = 2'd2; exp[6]  = 32'h0000_00FF;
        lt[7]  = 3'b001; off[7]  = 2'd3; exp[7]  = 32'hFFFF_80FF;
        lt[8]  = 3'b011; off[8]  = 2'd2; exp[8]  = 32'h80FF_7F01;
        lt[9]  = 3'b101; off[9]  = 2'd2; exp[9]  = 32'h0000_80FF;
        lt[10] = 3'b001; off[10] = 2'd1; exp[10] = 32'h0000_7F01;
        bus.rs1_addr = 4'd7;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 4'd7, {28'h0000_010, 2'b00, off[i]}, 32'h80FF_7F01, 1'b1, lt[i]);
            tick();
            checks_total++;
            if (bus.fwd_data !== exp[i]) $display("FAIL load[%0d] got=%h exp=%h", i, bus.fwd_data, exp[i]);
            else checks_passed++;
            checks_total++;
            if (bus.rs1_data !== exp[i]) $display("FAIL load_bypass[%0d] got=%h exp=%h", i, bus.rs1_data, exp[i]);
            else checks_passed++;
        end
        drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 3'b000);
        tick();
        checks_total++;
        if (bus.retire_count !== 32'd12) $display("FAIL load_retire got=%0d exp=12", bus.retire_count);
        else checks_passed++;
    endtask

    task automatic test_r0();
        drive(1'b1, 4'd0, 32'hDEAD_BEEF, 32'h0, 1'b0, 3'b000);
        tick();
        drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 3'b000);
        bus.rs1_addr = 4'd0;
        #1;
        checks_total++;
        if (bus.fwd_valid !== 1'b0) $display("FAIL r0_fwd_valid got=%b exp=0", bus.fwd_valid);
        else checks_passed++;
        checks_total++;
        if (bus.rs1_data !== 32'h0) $display("FAIL r0_bypass got=%h exp=0", bus.rs1_data);
        else checks_passed++;
        tick();
        checks_total++;
        if (bus.rs1_data !== 32'h0) $display("FAIL r0_rf got=%h exp=0", bus.rs1_data);
        else checks_passed++;
        checks_total++;
        if (bus.retire_count !== 32'd13) $display("FAIL r0_retire got=%0d exp=13", bus.retire_count);
        else checks_passed++;
    endtask

    task automatic test_back_to_back();
        bus.rs1_addr = 4'd3;
        bus.rs2_addr = 4'd3;
        drive(1'b1, 4'd3, 32'd1, 32'h0, 1'b0, 3'b000);
        tick();
        drive(1'b1, 4'd3, 32'd2, 32'h0, 1'b0, 3'b000);
        tick();
        checks_total++;
        if (bus.rs1_data !== 32'd2) $display("FAIL b2b_rs1_young got=%h exp=2", bus.rs1_data);
        else checks_passed++;
        checks_total++;
        if (bus.rs2_data !== 32'd2) $display("FAIL b2b_rs2_young got=%h exp=2", bus.rs2_data);
        else checks_passed++;
        drive(1'b0, 4'd3, 32'd9, 32'h0, 1'b0, 3'b000);
        tick();
        checks_total++;
        if (bus.fwd_valid !== 1'b0) $display("FAIL bubble_fwd_valid got=%b exp=0", bus.fwd_valid);
        else checks_passed++;
        checks_total++;
        if (bus.rs1_data !== 32'd2) $display("FAIL bubble_no_bypass got=%h exp=2", bus.rs1_data);
        else checks_passed++;
        drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 3'b000);
        tick();
        checks_total++;
        if (bus.rs1_data !== 32'd2) $display("FAIL bubble_no_write got=%h exp=2", bus.rs1_data);
        else checks_passed++;
        checks_total++;
        if (bus.retire_count !== 32'd15) $display("FAIL b2b_retire got=%0d exp=15", bus.retire_count);
        else checks_passed++;
        // Reset while r3 = 7 sits in MEM/WB
        drive(1'b1, 4'd3, 32'd7, 32'h0, 1'b0, 3'b000);
        tick();
        checks_total++;
        if (bus.rs1_data !== 32'd7) $display("FAIL rst_pre_bypass got=%h exp=7", bus.rs1_data);
        else checks_passed++;
        rst = 1'b1;
        drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 3'b000);
        tick();
        rst = 1'b0;
        #1;
        checks_total++;
        if (bus.rs1_data !== 32'd0) $display("FAIL rst_mid_r3 got=%h exp=0", bus.rs1_data);
        else checks_passed++;
        checks_total++;
        if (bus.retire_count !== 32'd0) $display("FAIL rst_mid_retire got=%0d exp=0", bus.retire_count);
        else checks_passed++;
        tick();
        checks_total++;
        if (bus.rs1_data !== 32'd0) $display("FAIL rst_mid_r3_after got=%h exp=0", bus.rs1_data);
        else checks_passed++;
        checks_total++;
        if (bus.retire_count !== 32'd0) $display("FAIL rst_mid_retire_after got=%0d exp=0", bus.retire_count);
        else checks_passed++;
    endtask

    task automatic test_wrap();
        // MEM/WB holds a bubble here, so the preloaded value is not bumped at the next edge
        force dut.r_retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_count;
        drive(1'b1, 4'd4, 32'h0000_00A5, 32'h0, 1'b0, 3'b000);
        bus.rs1_addr = 4'd4;
        tick();
        checks_total++;
        if (bus.retire_count !== 32'hFFFF_FFFF) $display("FAIL wrap_preload got=%h exp=ffffffff", bus.retire_count);
        else checks_passed++;
        drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 3'b000);
        tick();
        checks_total++;
        if (bus.retire_count !== 32'h0) $display("FAIL wrap_retire got=%h exp=0", bus.retire_count);
        else checks_passed++;
        checks_total++;
        if (bus.rs1_data !== 32'h0000_00A5) $display("FAIL wrap_r4 got=%h exp=a5", bus.rs1_data);
        else checks_passed++;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst           = 1'b1;
        bus.rs1_addr  = 4'd0;
        bus.rs2_addr  = 4'd0;
        drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 3'b000);
        test_reset();
        test_alu_write();
        test_loads();
        test_r0();
        test_back_to_back();
        test_wrap();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the CPU core pipeline, directly downstream of the memory stage. Registers the memory stage's result into a MEM/WB pipeline register, sign/zero-extends and aligns load data, and commits the result to a 16 x 32-bit register file. Also provides decode-side read ports with write-through bypass, an EX-side forwarding tap, and a retired-instruction counter.

## Interface
- NUM_REGS, 16: register file depth; fixed by the 4-bit register index.
- XLEN, 32: datapath width.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_in  in  4  destination register from the memory stage.
- alu_in  in  32  ALU result; also the load byte address.
- mem_data_in  in  32  raw data-memory read word.
- is_load_in  in  1  1 selects load data, 0 selects alu_in.
- ld_type_in  in  3  [1:0] size: 00 byte, 01 half, 10 word, 11 reserved. [2]: 1 means zero-extend.
- valid_in  in  1  memory-stage result valid; already low while a load waits on dmem_ready.
- rs1_addr, rs2_addr  in  4 each  decode read addresses.
- rs1_data, rs2_data  out  32 each  decode read data.
- fwd_valid  out  1  MEM/WB register holds a valid write to a nonzero register.
- fwd_rd  out  4  MEM/WB destination register.
- fwd_data  out  32  MEM/WB final result.
- retire_count  out  32  number of valid instructions retired.

## Operation
- The MEM/WB register is written on every clock edge, with no stall input:
  - wb_valid_q <= valid_in
  - wb_rd_q <= rd_in
  - wb_data_q <= the result selected below.
- Result select when is_load_in = 0: alu_in.
- Result select when is_load_in = 1, with byte offset off = alu_in[1:0]:
  - Byte: mem_data_in[8*off+7 : 8*off], extended to 32 bits.
  - Half: mem_data_in[15:0] if off[1] = 0, else [31:16], extended. off[0] is ignored; misaligned halves are not trapped.
  - Word: mem_data_in, with off ignored.
  - Reserved size 11: treated as word.
  - Extension is sign extension unless ld_type_in[2] = 1, which gives zero extension.
- Register file commit: when wb_valid_q = 1 and wb_rd_q != 0, regs[wb_rd_q] <= wb_data_q at the next edge.
- r0 is hardwired to zero: writes to it are dropped and reads of it return 0.
- Read ports are combinational. If rsN_addr == wb_rd_q, wb_valid_q = 1 and the address is nonzero, rsN_data = wb_data_q (write-through bypass). Otherwise rsN_data = regs[rsN_addr].
- Forwarding tap:
  - fwd_valid = wb_valid_q & (wb_rd_q != 0)
  - fwd_rd = wb_rd_q
  - fwd_data = wb_data_q
- retire_count increments by 1 on each edge where wb_valid_q = 1, including when rd = 0. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (synchronous, at an edge with rst = 1):
  - wb_valid_q = 0, wb_rd_q = 0, wb_data_q = 0.
  - All registers = 0 and retire_count = 0.
  - In the following cycle: fwd_valid = 0, fwd_rd = 0, fwd_data = 0, and rs1_data / rs2_data = 0 for every address.
- Reset mid-operation: a commit pending in the MEM/WB register at the reset edge is discarded; reset has priority over the commit and the counter increment.
- Latency:
  - An instruction presented at edge E appears on fwd_* during cycle E..E+1.
  - It is visible on the read ports via bypass in that same cycle.
  - It is architecturally written and counted at edge E+1.
- Back-to-back writes to the same register: the later one wins.
  - The read port shows the younger value as soon as it reaches MEM/WB.
  - At no point does a read return the overwritten older value once the younger one is in MEM/WB.
- Bubbles (valid_in = 0): the register is loaded with valid 0. There is no write, no count, and no bypass, regardless of rd_in and data.
- rs1_addr == rs2_addr: both ports return identical data, bypass included.

## Test plan
- Reset then read every address: all rs data = 0, fwd_valid = 0, retire_count = 0.
- ALU write: valid_in = 1, rd = 5, alu_in = 0x1234_5678, is_load = 0 at edge E.
  - During the next cycle: fwd_valid = 1, fwd_rd = 5, and rs1_addr = 5 reads 0x1234_5678 via bypass.
  - After edge E+1: the same value is read from the register file and retire_count = 1.
- Loads with mem_data_in = 0x80FF_7F01:
  - byte, off 3, signed -> 0xFFFF_FF80
  - byte, off 0, unsigned -> 0x0000_0001
  - half, off 2, signed -> 0xFFFF_80FF
  - half, off 0, unsigned -> 0x0000_7F01
  - word, off 1 -> 0x80FF_7F01
- r0 protection: valid write with rd = 0, data 0xDEAD_BEEF -> fwd_valid = 0, rs1_addr = 0 reads 0, retire_count still increments.
- Bubble and ordering: write r3 = 1 then r3 = 2 back-to-back, then valid_in = 0 with rd = 3 and data 9.
  - r3 reads 2 and retire_count advances by exactly 2.
  - Assert rst while r3 = 7 is in MEM/WB: afterwards r3 = 0 and retire_count = 0.
- Counter wrap: preload retire_count to 0xFFFF_FFFF by force/backdoor, retire one instruction -> retire_count = 0.
